// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_pkg
// Purpose  : Shared state encodings, grantee codes and default widths for
//            the memory arbiter.
// Revision : 1.0
// ============================================================================
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_SETUP   = 2'd1,
        ARB_STROBE  = 2'd2,
        ARB_CAPTURE = 2'd3
    } arb_state_t;

    typedef enum logic {
        GNT_FETCH = 1'b0,
        GNT_DATA  = 1'b1
    } grantee_t;

    localparam int c_addr_width   = 8;
    localparam int c_data_width   = 8;
    localparam int c_starve_limit = 4;
    // Wide enough for any limit in 1..15.
    localparam int c_starve_cnt_w = 4;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_starve_counter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_starve_counter
// Purpose  : Counts data grants taken while fetch waits; raises force_fetch
//            once the count reaches STARVE_LIMIT.
// Revision : 1.0
// ============================================================================
module mem_arbiter_starve_counter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = c_starve_limit
) (
    input  logic clock,
    input  logic reset_n,
    input  logic arb_idle,
    input  logic fetch_req,
    input  logic data_grant,
    input  logic fetch_grant,
    output logic force_fetch
);

    localparam logic [c_starve_cnt_w-1:0] c_limit = STARVE_LIMIT[c_starve_cnt_w-1:0];

    logic [c_starve_cnt_w-1:0] r_count;

    // Only evaluated in IDLE: that is where grants happen and fetch_req is sampled.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (arb_idle) begin
            if (fetch_grant || !fetch_req) begin
                r_count <= '0;
            end else if (data_grant && (r_count != c_limit)) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign force_fetch = (r_count == c_limit);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Serialises fetch and load/store accesses onto one memory port,
//            generating the mem_clock strobe; data has priority.
// Revision : 1.0
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = c_addr_width,
    parameter int DATA_WIDTH   = c_data_width,
    parameter int STARVE_LIMIT = c_starve_limit
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_ack,
    output logic [DATA_WIDTH-1:0] fetch_data,
    input  logic                  data_req,
    input  logic                  data_we,
    input  logic [ADDR_WIDTH-1:0] data_addr,
    input  logic [DATA_WIDTH-1:0] data_wdata,
    output logic                  data_ack,
    output logic [DATA_WIDTH-1:0] data_rdata,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] to_mem,
    input  logic [DATA_WIDTH-1:0] from_mem,
    output logic                  mem_clock,
    output logic                  mem_write,
    output logic                  busy
);

    arb_state_t r_state;
    arb_state_t w_state_next;
    grantee_t   r_grantee;

    logic w_idle;
    logic w_force_fetch;
    logic w_fetch_wins;
    logic w_grant_fetch;
    logic w_grant_data;

    assign w_idle        = (r_state == ARB_IDLE);
    assign w_fetch_wins  = fetch_req && (!data_req || w_force_fetch);
    assign w_grant_fetch = w_idle && w_fetch_wins;
    assign w_grant_data  = w_idle && data_req && !w_fetch_wins;

    mem_arbiter_starve_counter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clock       (clock),
        .reset_n     (reset_n),
        .arb_idle    (w_idle),
        .fetch_req   (fetch_req),
        .data_grant  (w_grant_data),
        .fetch_grant (w_grant_fetch),
        .force_fetch (w_force_fetch)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ARB_IDLE:    if (fetch_req || data_req) w_state_next = ARB_SETUP;
            ARB_SETUP:   w_state_next = ARB_STROBE;
            ARB_STROBE:  w_state_next = ARB_CAPTURE;
            ARB_CAPTURE: w_state_next = ARB_IDLE;
            default:     w_state_next = ARB_IDLE;
        endcase
    end

    // Outputs are registered off the current state so each appears one cycle
    // after the transition that calls for it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            address    <= '0;
            to_mem     <= '0;
            mem_clock  <= 1'b0;
            mem_write  <= 1'b0;
            fetch_ack  <= 1'b0;
            data_ack   <= 1'b0;
            fetch_data <= '0;
            data_rdata <= '0;
            busy       <= 1'b0;
            r_grantee  <= GNT_FETCH;
        end else begin
            fetch_ack <= 1'b0;
            data_ack  <= 1'b0;
            busy      <= (w_state_next != ARB_IDLE);
            case (r_state)
                ARB_IDLE: begin
                    if (w_grant_data) begin
                        address   <= data_addr;
                        to_mem    <= data_wdata;
                        mem_write <= data_we;
                        r_grantee <= GNT_DATA;
                    end else if (w_grant_fetch) begin
                        address   <= fetch_addr;
                        mem_write <= 1'b0;
                        r_grantee <= GNT_FETCH;
                    end
                end
                ARB_SETUP: begin
                    mem_clock <= 1'b1;
                end
                ARB_STROBE: begin
                    mem_clock <= 1'b0;
                    mem_write <= 1'b0;
                    if (r_grantee == GNT_FETCH) begin
                        fetch_data <= from_mem;
                        fetch_ack  <= 1'b1;
                    end else begin
                        data_ack <= 1'b1;
                        if (!mem_write) data_rdata <= from_mem;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed self-checking bench for mem_arbiter with a small
//            behavioural memory on the shared port.
// Revision : 1.0
// ============================================================================
module tb_mem_arbiter;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       fetch_req;
    logic [7:0] fetch_addr;
    logic       fetch_ack;
    logic [7:0] fetch_data;
    logic       data_req;
    logic       data_we;
    logic [7:0] data_addr;
    logic [7:0] data_wdata;
    logic       data_ack;
    logic [7:0] data_rdata;
    logic [7:0] address;
    logic [7:0] to_mem;
    logic [7:0] from_mem;
    logic       mem_clock;
    logic       mem_write;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int mc_cnt = 0;
    int mw_cnt = 0;

    logic       prev_ack   = 1'b0;
    logic       prev_mc    = 1'b0;
    logic       prev_busy  = 1'b0;
    logic [7:0] prev_addr  = 8'h00;

    always #5 clock = ~clock;

    mem_arbiter #(
        .ADDR_WIDTH   (8),
        .DATA_WIDTH   (8),
        .STARVE_LIMIT (4)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_ack  (fetch_ack),
        .fetch_data (fetch_data),
        .data_req   (data_req),
        .data_we    (data_we),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .data_ack   (data_ack),
        .data_rdata (data_rdata),
        .address    (address),
        .to_mem     (to_mem),
        .from_mem   (from_mem),
        .mem_clock  (mem_clock),
        .mem_write  (mem_write),
        .busy       (busy)
    );

    // Unwritten locations read as addr+0x10; read data is only valid while mem_clock is high.
    logic [7:0] store   [256];
    bit         written [256];

    always @(posedge mem_clock) begin
        if (mem_write) begin
            store[address]   <= to_mem;
            written[address] <= 1'b1;
        end
    end

    assign from_mem = !mem_clock ? 8'hEE :
                      (written[address] ? store[address] : address + 8'h10);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next negedge and check the port invariants there.
    task automatic tick();
        @(negedge clock);
        cyc++;
        if (reset_n) begin
            chk("one_ack", {31'b0, fetch_ack & data_ack}, 32'd0);
            chk("ack_gap", {31'b0, prev_ack & (fetch_ack | data_ack)}, 32'd0);
            chk("mclk_width", {31'b0, prev_mc & mem_clock}, 32'd0);
            if (prev_busy && busy) chk("addr_stable", {24'b0, address}, {24'b0, prev_addr});
            mc_cnt += int'(mem_clock);
            mw_cnt += int'(mem_write);
            prev_ack  = fetch_ack | data_ack;
            prev_mc   = mem_clock;
            prev_busy = busy;
            prev_addr = address;
        end else begin
            prev_ack  = 1'b0;
            prev_mc   = 1'b0;
            prev_busy = 1'b0;
        end
    endtask

    // which: 1 = fetch ack, 2 = data ack, 0 = none within the budget.
    task automatic wait_ack(output int which);
        which = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (fetch_ack) begin which = 1; break; end
            if (data_ack)  begin which = 2; break; end
        end
    endtask

    initial begin
        int which;
        int t0;
        int mc0;
        int mw0;
        int found;

        reset_n    = 1'b0;
        fetch_req  = 1'b0;
        fetch_addr = 8'h00;
        data_req   = 1'b0;
        data_we    = 1'b0;
        data_addr  = 8'h00;
        data_wdata = 8'h00;
        repeat (3) tick();

        chk("rst_ctrl", {27'b0, busy, mem_clock, mem_write, fetch_ack, data_ack}, 32'd0);
        chk("rst_address", {24'b0, address}, 32'd0);
        chk("rst_to_mem", {24'b0, to_mem}, 32'd0);
        chk("rst_fetch_data", {24'b0, fetch_data}, 32'd0);
        chk("rst_data_rdata", {24'b0, data_rdata}, 32'd0);
        reset_n = 1'b1;
        tick();

        // Fetch-only stream
        mw0        = mw_cnt;
        fetch_req  = 1'b1;
        fetch_addr = 8'h00;
        t0         = cyc;
        for (int i = 0; i < 4; i++) begin
            wait_ack(which);
            chk("fetch_who", which, 1);
            if (i == 0) chk("fetch_latency", cyc - t0, 3);
            else        chk("fetch_interval", cyc - t0, 4);
            t0 = cyc;
            chk("fetch_data", {24'b0, fetch_data}, 32'h10 + i);
            if (i < 3) fetch_addr = 8'(i + 1);
            else       fetch_req  = 1'b0;
        end
        chk("fetch_no_write", mw_cnt - mw0, 0);
        tick();
        chk("idle_busy", {31'b0, busy}, 32'd0);

        // Store 0xA5 to 0x80
        mc0        = mc_cnt;
        mw0        = mw_cnt;
        data_req   = 1'b1;
        data_we    = 1'b1;
        data_addr  = 8'h80;
        data_wdata = 8'hA5;
        wait_ack(which);
        chk("store_who", which, 2);
        chk("store_mw_capture", {31'b0, mem_write}, 32'd0);
        data_req = 1'b0;
        chk("store_mclk", mc_cnt - mc0, 1);
        chk("store_mw_cycles", mw_cnt - mw0, 2);
        tick();

        // Load back from 0x80
        mc0        = mc_cnt;
        mw0        = mw_cnt;
        data_req   = 1'b1;
        data_we    = 1'b0;
        data_wdata = 8'h00;
        wait_ack(which);
        chk("load_who", which, 2);
        chk("load_rdata", {24'b0, data_rdata}, 32'hA5);
        data_req = 1'b0;
        chk("load_mclk", mc_cnt - mc0, 1);
        chk("load_mw_cycles", mw_cnt - mw0, 0);
        chk("load_fetch_held", {24'b0, fetch_data}, 32'h13);
        tick();

        // Collision: data first, fetch four cycles later
        fetch_req  = 1'b1;
        fetch_addr = 8'h02;
        data_req   = 1'b1;
        data_addr  = 8'h01;
        wait_ack(which);
        chk("coll_first", which, 2);
        chk("coll_rdata", {24'b0, data_rdata}, 32'h11);
        data_req = 1'b0;
        t0       = cyc;
        wait_ack(which);
        chk("coll_second", which, 1);
        chk("coll_interval", cyc - t0, 4);
        chk("coll_fetch_data", {24'b0, fetch_data}, 32'h12);
        fetch_req = 1'b0;
        tick();

        // Starvation: D D D D F then D again once the counter has cleared
        fetch_req  = 1'b1;
        fetch_addr = 8'h00;
        data_req   = 1'b1;
        data_we    = 1'b0;
        data_addr  = 8'h80;
        for (int i = 0; i < 6; i++) begin
            wait_ack(which);
            chk("starve_order", which, (i == 4) ? 1 : 2);
        end
        data_req  = 1'b0;
        fetch_req = 1'b0;
        chk("starve_fetch_data", {24'b0, fetch_data}, 32'h10);
        chk("starve_rdata", {24'b0, data_rdata}, 32'hA5);
        tick();

        // Reset during STROBE aborts the access
        fetch_req  = 1'b1;
        fetch_addr = 8'h05;
        found      = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (mem_clock) begin found = 1; break; end
        end
        chk("strobe_seen", found, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_ctrl", {27'b0, busy, mem_clock, mem_write, fetch_ack, data_ack}, 32'd0);
        chk("abort_address", {24'b0, address}, 32'd0);
        chk("abort_fetch_data", {24'b0, fetch_data}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("abort_no_ack", {30'b0, fetch_ack, data_ack}, 32'd0);
        end
        reset_n = 1'b1;
        t0      = cyc;
        wait_ack(which);
        chk("reissue_who", which, 1);
        chk("reissue_latency", cyc - t0, 3);
        chk("reissue_data", {24'b0, fetch_data}, 32'h15);
        fetch_req = 1'b0;
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
